alu_issue_stage: RTL and testbench

//  Issue/execute front end for the single-cycle ALU: accepts decoded-register

---
 rtl/alu_issue_stage.sv | 195 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// Issue/writeback pipeline around an external single-cycle ALU: decode, operand registers, result capture.
// Optional macro ALU_BYPASS_EN forwards in-flight results to the incoming operands.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic [XLEN-1:0] alu_oprd1,
  output logic [XLEN-1:0] alu_oprd2,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_zero,
  output logic            wb_illegal
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1000;
  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;

  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] alu_oprd1_q, alu_oprd1_d;
  logic [XLEN-1:0] alu_oprd2_q, alu_oprd2_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [4:0]      s1_rd_q, s1_rd_d;
  logic            s1_we_q, s1_we_d;
  logic            s1_illegal_q, s1_illegal_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic            wb_we_q, wb_we_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_zero_q, wb_zero_d;
  logic            wb_illegal_q, wb_illegal_d;

  logic            s2_adv, accept;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            dec_legal, dec_is_i;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] imm_sext, rs1_val, rs2_val;

  assign opcode   = in_instr[6:0];
  assign rd       = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign imm_sext = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

  assign s2_adv   = !wb_valid_q || wb_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_is_i  = (opcode == OPC_I);
    if (opcode == OPC_R || opcode == OPC_I) begin
      dec_legal = 1'b1;
      case (funct3)
        3'b000:  dec_op = OP_ADD;
        3'b111:  dec_op = OP_AND;
        3'b110:  dec_op = OP_OR;
        3'b100:  dec_op = OP_XOR;
        3'b010:  dec_op = OP_SLT;
        default: dec_legal = 1'b0;
      endcase
      // funct7 only qualifies R-type; 0100000 is meaningful for f3=000 alone
      if (opcode == OPC_R) begin
        if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_op = OP_SUB;
        else if (funct7 != 7'b0000000) dec_legal = 1'b0;
      end
    end
    if (!dec_legal) dec_op = OP_ADD;
  end

`ifdef ALU_BYPASS_EN
  logic [4:0] rs1, rs2;
  assign rs1 = in_instr[19:15];
  assign rs2 = in_instr[24:20];

  // s1 is younger than s2, so it wins when both target the same register
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
    if (rs1 != 5'd0) begin
      if (s1_valid_q && s1_we_q && s1_rd_q == rs1) rs1_val = alu_result;
      else if (wb_valid_q && wb_we_q && wb_rd_q == rs1) rs1_val = wb_data_q;
    end
    if (rs2 != 5'd0) begin
      if (s1_valid_q && s1_we_q && s1_rd_q == rs2) rs2_val = alu_result;
      else if (wb_valid_q && wb_we_q && wb_rd_q == rs2) rs2_val = wb_data_q;
    end
  end
`else
  logic unused_rs1_field;
  assign unused_rs1_field = ^in_instr[19:15];
  assign rs1_val = in_rs1_data;
  assign rs2_val = in_rs2_data;
`endif

  always_comb begin
    s1_valid_d   = s1_valid_q;
    alu_oprd1_d  = alu_oprd1_q;
    alu_oprd2_d  = alu_oprd2_q;
    alu_op_d     = alu_op_q;
    s1_rd_d      = s1_rd_q;
    s1_we_d      = s1_we_q;
    s1_illegal_d = s1_illegal_q;
    wb_valid_d   = wb_valid_q;
    wb_rd_d      = wb_rd_q;
    wb_we_d      = wb_we_q;
    wb_data_d    = wb_data_q;
    wb_zero_d    = wb_zero_q;
    wb_illegal_d = wb_illegal_q;

    if (accept) begin
      s1_valid_d   = 1'b1;
      alu_op_d     = dec_op;
      s1_rd_d      = rd;
      s1_we_d      = dec_legal && (rd != 5'd0);
      s1_illegal_d = !dec_legal;
      alu_oprd1_d  = dec_legal ? rs1_val : '0;
      alu_oprd2_d  = !dec_legal ? '0 : (dec_is_i ? imm_sext : rs2_val);
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      wb_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        wb_rd_d      = s1_rd_q;
        wb_we_d      = s1_we_q;
        wb_illegal_d = s1_illegal_q;
        wb_data_d    = s1_illegal_q ? '0 : alu_result;
        wb_zero_d    = alu_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      alu_oprd1_q  <= '0;
      alu_oprd2_q  <= '0;
      alu_op_q     <= OP_ADD;
      s1_rd_q      <= '0;
      s1_we_q      <= 1'b0;
      s1_illegal_q <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_we_q      <= 1'b0;
      wb_data_q    <= '0;
      wb_zero_q    <= 1'b0;
      wb_illegal_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      alu_oprd1_q  <= alu_oprd1_d;
      alu_oprd2_q  <= alu_oprd2_d;
      alu_op_q     <= alu_op_d;
      s1_rd_q      <= s1_rd_d;
      s1_we_q      <= s1_we_d;
      s1_illegal_q <= s1_illegal_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_we_q      <= wb_we_d;
      wb_data_q    <= wb_data_d;
      wb_zero_q    <= wb_zero_d;
      wb_illegal_q <= wb_illegal_d;
    end
  end

  assign alu_oprd1  = alu_oprd1_q;
  assign alu_oprd2  = alu_oprd2_q;
  assign alu_op     = alu_op_q;
  assign wb_valid   = wb_valid_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_zero    = wb_zero_q;
  assign wb_illegal = wb_illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU closing the loop.
// Build with ALU_BYPASS_EN defined to check the forwarding variant.
module tb_alu_issue_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1_data, in_rs2_data;
  logic [XLEN-1:0] alu_oprd1, alu_oprd2, alu_result;
  logic [3:0]      alu_op;
  logic            alu_zero;
  logic            wb_valid, wb_ready, wb_we, wb_zero, wb_illegal;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .alu_oprd1(alu_oprd1), .alu_oprd2(alu_oprd2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_zero(wb_zero), .wb_illegal(wb_illegal)
  );

  // reference single-cycle ALU
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000: alu_result = alu_oprd1 & alu_oprd2;
      4'b0001: alu_result = alu_oprd1 | alu_oprd2;
      4'b0010: alu_result = alu_oprd1 + alu_oprd2;
      4'b0110: alu_result = alu_oprd1 - alu_oprd2;
      4'b0111: alu_result = ($signed(alu_oprd1) < $signed(alu_oprd2)) ? 32'd1 : 32'd0;
      4'b1000: alu_result = alu_oprd1 ^ alu_oprd2;
      4'b1100: alu_result = ~(alu_oprd1 | alu_oprd2);
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        zero;
    logic        illegal;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic acc_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // in-flight entries are exactly the un-popped scoreboard entries; youngest match wins
  function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] raw);
    logic [31:0] v;
    v = raw;
`ifdef ALU_BYPASS_EN
    if (rs != 5'd0)
      for (int i = 0; i < sb.size(); i++)
        if (sb[i].we && sb[i].rd == rs) v = sb[i].data;
`endif
    return v;
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] ra,
                                 input logic [31:0] rb);
    exp_t e;
    logic [31:0] a, b, r;
    logic ok, f7z;
    a = fwd(ins[19:15], ra);
    b = 32'd0;
    r = 32'd0;
    ok = 1'b0;
    f7z = (ins[31:25] == 7'd0);
    if (ins[6:0] == 7'b0110011) begin
      b = fwd(ins[24:20], rb);
      case (ins[14:12])
        3'b000: if (f7z) begin ok = 1'b1; r = a + b; end
                else if (ins[31:25] == 7'b0100000) begin ok = 1'b1; r = a - b; end
        3'b111: begin ok = f7z; r = a & b; end
        3'b110: begin ok = f7z; r = a | b; end
        3'b100: begin ok = f7z; r = a ^ b; end
        3'b010: begin ok = f7z; r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        default: ok = 1'b0;
      endcase
    end else if (ins[6:0] == 7'b0010011) begin
      b = {{20{ins[31]}}, ins[31:20]};
      ok = 1'b1;
      case (ins[14:12])
        3'b000: r = a + b;
        3'b111: r = a & b;
        3'b110: r = a | b;
        3'b100: r = a ^ b;
        3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: ok = 1'b0;
      endcase
    end
    e.rd      = ins[11:7];
    e.illegal = !ok;
    e.we      = ok && (ins[11:7] != 5'd0);
    e.data    = ok ? r : 32'd0;
    e.zero    = ok ? (r == 32'd0) : 1'b1;
    return e;
  endfunction

  // called just after a negedge; handshakes resolve at the following posedge
  task automatic tick();
    exp_t e_new, e;
    #1;
    acc_last = in_valid && in_ready;
    e_new = model(in_instr, in_rs1_data, in_rs2_data);
    if (wb_valid && wb_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("wb_data", wb_data, e.data);
        chk("wb_rd_we_zero_ill", {wb_rd, wb_we, wb_zero, wb_illegal},
            {e.rd, e.we, e.zero, e.illegal});
      end
    end
    if (acc_last) sb.push_back(e_new);
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input bit rand_ready);
    in_valid = 1'b1;
    in_instr = ins;
    in_rs1_data = a;
    in_rs2_data = b;
    for (int i = 0; i < 40; i++) begin
      if (rand_ready) wb_ready = 1'($urandom_range(0, 1));
      tick();
      if (acc_last) break;
    end
    chk("send_accepted", 64'(acc_last), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || wb_valid); i++) tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    wb_ready = 1'b0;
    acc_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd2);
    chk("rst_oprd1", alu_oprd1, 64'd0);
    chk("rst_oprd2", alu_oprd2, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // ADD x3,x1,x2 and one-edge capture into writeback
    wb_ready = 1'b1;
    send(r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, 1'b0);
    chk("lat_s1_only", 64'(wb_valid), 64'd0);
    tick();
    chk("lat_wb_valid", 64'(wb_valid), 64'd1);
    drain();

    // SUB to zero, signed SLT, back to back
    send(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd4), 32'd9, 32'd9, 1'b0);
    send(r_type(7'd0, 5'd2, 5'd1, 3'b010, 5'd6), 32'hFFFF_FFFF, 32'd1, 1'b0);
    drain();

    // ADDI x5,x0,-1
    send(i_type(12'hFFF, 5'd0, 3'b000, 5'd5), 32'd0, 32'h1234, 1'b0);
    chk("addi_alu_op", 64'(alu_op), 64'd2);
    chk("addi_oprd2", alu_oprd2, 64'hFFFF_FFFF);
    drain();

    // backpressure: two accepted, third held off for four cycles
    wb_ready = 1'b0;
    send(r_type(7'd0, 5'd2, 5'd1, 3'b111, 5'd11), 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
    send(r_type(7'd0, 5'd2, 5'd1, 3'b110, 5'd12), 32'h0000_1000, 32'h0000_0001, 1'b0);
    in_valid = 1'b1;
    in_instr = r_type(7'd0, 5'd2, 5'd1, 3'b100, 5'd13);
    in_rs1_data = 32'hAAAA_5555;
    in_rs2_data = 32'hFFFF_0000;
    #1;
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_no_accept", 64'(acc_last), 64'd0);
    end
    wb_ready = 1'b1;
    send(in_instr, in_rs1_data, in_rs2_data, 1'b0);
    drain();

    // illegal encodings and rd=x0
    send({12'd0, 5'd1, 3'b010, 5'd3, 7'b0000011}, 32'd8, 32'd9, 1'b0);
    send(r_type(7'd1, 5'd2, 5'd1, 3'b000, 5'd7), 32'd8, 32'd9, 1'b0);
    send(r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd0), 32'd8, 32'd9, 1'b0);
    send(i_type(12'h005, 5'd1, 3'b001, 5'd8), 32'd8, 32'd9, 1'b0);
    drain();

    // dependent pairs with stale register data (producer in s1, then in s2)
    send(r_type(7'd0, 5'd8, 5'd7, 3'b000, 5'd1), 32'd3, 32'd4, 1'b0);
    send(r_type(7'd0, 5'd1, 5'd1, 3'b000, 5'd2), 32'd0, 32'd0, 1'b0);
    send(r_type(7'd0, 5'd8, 5'd7, 3'b000, 5'd9), 32'd20, 32'd22, 1'b0);
    send(r_type(7'd0, 5'd8, 5'd7, 3'b000, 5'd0), 32'd1, 32'd1, 1'b0);
    send(r_type(7'd0, 5'd9, 5'd9, 3'b000, 5'd10), 32'd0, 32'd0, 1'b0);
    send(i_type(12'h001, 5'd10, 3'b000, 5'd11), 32'd0, 32'd0, 1'b0);
    drain();

    // random legal/illegal mix under random backpressure
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ins;
      logic [4:0] r1, r2, rdx;
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      rdx = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: ins = r_type(7'd0, r2, r1, 3'b000, rdx);
        1: ins = r_type(7'b0100000, r2, r1, 3'b000, rdx);
        2: ins = r_type(7'd0, r2, r1, 3'b111, rdx);
        3: ins = r_type(7'd0, r2, r1, 3'b110, rdx);
        4: ins = r_type(7'd0, r2, r1, 3'b100, rdx);
        5: ins = r_type(7'd0, r2, r1, 3'b010, rdx);
        6: ins = i_type(12'($urandom), r1, 3'b000, rdx);
        default: ins = i_type(12'($urandom), r1, 3'b010, rdx);
      endcase
      send(ins, $urandom, $urandom, 1'b1);
    end
    drain();

    // reset with both stages occupied
    wb_ready = 1'b0;
    send(r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd1, 32'd2, 1'b0);
    send(r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd4), 32'd3, 32'd4, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_wb_valid", 64'(wb_valid), 64'd0);
    chk("midrst_alu_op", 64'(alu_op), 64'd2);
    rst_n = 1'b1;
    sb.delete();
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    wb_ready = 1'b1;
    tick();
    chk("midrst_no_wb", 64'(wb_valid), 64'd0);
    send(r_type(7'd0, 5'd2, 5'd1, 3'b000, 5'd5), 32'd100, 32'd23, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
